// File: rtl/clock_period_monitor.sv
// Synchronizes a divided clock into clock_in, emits ticks on its rising edges and measures period/high time.
// Optional stall detection is compiled in with the CLKMON_STALL_EN macro.
module clock_period_monitor #(
    parameter int unsigned CNT_WIDTH      = 28,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 div_clock,
    input  logic                 enable,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 stalled,
    output logic [15:0]          edge_count
);

`ifdef CLKMON_STALL_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        STALL   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic                   s1;
    logic                   s2;
    logic                   s3;
    logic                   rise;
    logic                   fall;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   tick_next;
    logic                   pv_next;
    logic [CNT_WIDTH-1:0]   period_next;
    logic [CNT_WIDTH-1:0]   high_next;
    logic [15:0]            ec_next;

    // Synchronizer runs independently of enable so edges are clean on re-enable.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_clock;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        tick_next   = 1'b0;
        pv_next     = 1'b0;
        period_next = period;
        high_next   = high_time;
        ec_next     = edge_count;

        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ARM;
                    cnt_next   = '0;
                end
                ARM: begin
                    if (rise) begin
                        tick_next  = 1'b1;
                        cnt_next   = CNT_ONE;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        tick_next   = 1'b1;
                        pv_next     = 1'b1;
                        period_next = cnt;
                        cnt_next    = CNT_ONE;
                    end else begin
                        cnt_next = cnt_inc;
                        if (fall) begin
                            high_next = cnt;
                        end
`ifdef CLKMON_STALL_EN
                        // Stall is declared on the edge where cnt becomes TIMEOUT; a rise on that edge wins.
                        if (cnt_inc == TIMEOUT_VAL) begin
                            state_next = STALL;
                        end
`endif
                    end
                end
`ifdef CLKMON_STALL_EN
                STALL: begin
                    if (rise) begin
                        tick_next  = 1'b1;
                        cnt_next   = CNT_ONE;
                        state_next = MEASURE;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
`endif
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        if (tick_next) begin
            ec_next = edge_count + 16'd1;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            tick         <= 1'b0;
            period_valid <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            edge_count   <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            tick         <= tick_next;
            period_valid <= pv_next;
            period       <= period_next;
            high_time    <= high_next;
            edge_count   <= ec_next;
        end
    end

`ifdef CLKMON_STALL_EN
    assign stalled = (state == STALL);
`else
    assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed self-checking bench for clock_period_monitor (CNT_WIDTH=8, TIMEOUT_CYCLES=20).
// Stall checks run when CLKMON_STALL_EN is defined; otherwise saturation without stall is checked.
module tb_clock_period_monitor;

    localparam int unsigned W = 8;

    logic         clock_in;
    logic         reset;
    logic         div_clock;
    logic         enable;
    logic         tick;
    logic [W-1:0] period;
    logic         period_valid;
    logic [W-1:0] high_time;
    logic         stalled;
    logic [15:0]  edge_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int n_tick, n_pv, n_orphan, n_stall_obs;
    int last_tick = -1000;
    int last_gap  = 0;
    int stall_gap;
    logic first_pv, first_st;

    clock_period_monitor #(
        .CNT_WIDTH      (W),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .div_clock    (div_clock),
        .enable       (enable),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .high_time    (high_time),
        .stalled      (stalled),
        .edge_count   (edge_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one div_clock sample, then observe outputs 1 time unit after the edge.
    task automatic cyc(input logic d);
        div_clock = d;
        @(posedge clock_in);
        #1;
        cyc_n++;
        if (tick) begin
            n_tick++;
            last_gap  = cyc_n - last_tick;
            last_tick = cyc_n;
            if (n_tick == 1) begin
                first_pv = period_valid;
                first_st = stalled;
            end
        end
        if (period_valid) n_pv++;
        if (period_valid && !tick) n_orphan++;
        if (stalled) n_stall_obs++;
    endtask

    task automatic clear();
        n_tick      = 0;
        n_pv        = 0;
        n_stall_obs = 0;
        first_pv    = 1'bx;
        first_st    = 1'bx;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) cyc(1'b1);
            for (int i = 0; i < lo; i++) cyc(1'b0);
        end
    endtask

    initial begin
        n_orphan  = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        div_clock = 1'b0;
        clear();
        for (int i = 0; i < 3; i++) cyc(1'b0);
        check("rst_tick", tick, 0);
        check("rst_pvalid", period_valid, 0);
        check("rst_stalled", stalled, 0);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_edges", edge_count, 0);

        // Divide-by-10
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0);
        clear();
        wave(5, 5, 6);
        check("d10_ticks", n_tick, 6);
        check("d10_first_pv", first_pv, 0);
        check("d10_pvalids", n_pv, 5);
        check("d10_period", period, 10);
        check("d10_high", high_time, 5);
        check("d10_gap", last_gap, 10);
        check("d10_edges", edge_count, 6);

        // Divide-by-2
        clear();
        wave(1, 1, 8);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        check("d2_ticks", n_tick, 8);
        check("d2_pvalids", n_pv, 8);
        check("d2_period", period, 2);
        check("d2_high", high_time, 1);
        check("d2_gap", last_gap, 2);
        check("d2_edges", edge_count, 14);

        // Enable gating
        clear();
        wave(5, 5, 3);
        enable = 1'b0;
        clear();
        wave(5, 5, 3);
        check("dis_ticks", n_tick, 0);
        check("dis_pvalids", n_pv, 0);
        check("dis_period", period, 10);
        check("dis_high", high_time, 5);
        check("dis_edges", edge_count, 17);
        enable = 1'b1;
        clear();
        wave(5, 5, 3);
        check("reen_ticks", n_tick, 3);
        check("reen_first_pv", first_pv, 0);
        check("reen_pvalids", n_pv, 2);
        check("reen_period", period, 10);
        check("reen_edges", edge_count, 20);

`ifdef CLKMON_STALL_EN
        // Stall and recovery
        clear();
        for (int i = 0; i < 5; i++) cyc(1'b1);
        stall_gap = -1;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0);
            if (stalled) begin
                stall_gap = cyc_n - last_tick;
                break;
            end
        end
        check("stall_delay", stall_gap, 19);
        for (int i = 0; i < 10; i++) cyc(1'b0);
        check("stall_hold", stalled, 1);
        check("stall_ticks", n_tick, 1);
        clear();
        wave(5, 5, 3);
        check("recov_ticks", n_tick, 3);
        check("recov_stalled", first_st, 0);
        check("recov_first_pv", first_pv, 0);
        check("recov_pvalids", n_pv, 2);
        check("recov_period", period, 10);
        check("recov_stalled_now", stalled, 0);

        // Period 19: rise lands on the timeout edge, so no stall
        clear();
        wave(10, 9, 3);
        check("p19_stall_seen", n_stall_obs, 0);
        check("p19_pvalids", n_pv, 3);
        check("p19_period", period, 19);
        check("p19_high", high_time, 10);
        check("p19_edges", edge_count, 27);
`else
        // Without stall detection cnt saturates and MEASURE persists
        clear();
        for (int i = 0; i < 3; i++) cyc(1'b1);
        clear();
        for (int i = 0; i < 300; i++) cyc(1'b0);
        check("nostall_seen", n_stall_obs, 0);
        check("nostall_ticks", n_tick, 0);
        clear();
        for (int i = 0; i < 3; i++) cyc(1'b1);
        check("sat_pvalids", n_pv, 1);
        check("sat_period", period, 255);
        check("sat_edges", edge_count, 22);
`endif

        // Edge counter wrap
        force dut.edge_count = 16'hFFFF;
        #1;
        release dut.edge_count;
        clear();
        for (int i = 0; i < 2; i++) cyc(1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1);
        check("wrap_ticks", n_tick, 1);
        check("wrap_edges", edge_count, 0);

        // Asynchronous reset mid-count
        for (int i = 0; i < 2; i++) cyc(1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tick", tick, 0);
        check("arst_pvalid", period_valid, 0);
        check("arst_stalled", stalled, 0);
        check("arst_period", period, 0);
        check("arst_high", high_time, 0);
        check("arst_edges", edge_count, 0);
        for (int i = 0; i < 2; i++) cyc(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) cyc(1'b0);
        clear();
        for (int i = 0; i < 3; i++) cyc(1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0);
        check("post_rst_ticks", n_tick, 1);
        check("post_rst_first_pv", first_pv, 0);
        check("post_rst_pvalids", n_pv, 0);
        check("post_rst_edges", edge_count, 1);

        check("orphan_pvalid", n_orphan, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_period_monitor.md
# clock_period_monitor

Downstream consumer of the divided clock. Synchronizes a divided clock into the `clock_in` domain and emits one-cycle `tick` pulses on its rising edges. Measures period and high time in `clock_in` cycles and flags a stalled divider. Used to drive clock-enabled logic from the divider output and to check the divider at run time.

## Interface

**Parameters**

- `CNT_WIDTH`, 28: width of the period, high-time and internal counters.
- `TIMEOUT_CYCLES`, 28'd1000: `clock_in` cycles without a rising edge before a stall is declared. Must be ≥ 2 and < 2^CNT_WIDTH−1.

**Ports**

- `clock_in` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `div_clock` in 1: divided clock under observation; treated as asynchronous.
- `enable` in 1: monitor enable; level-sensitive.
- `tick` out 1: one-cycle pulse per synchronized rising edge of `div_clock`.
- `period` out CNT_WIDTH: last measured rising-to-rising period in `clock_in` cycles.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `high_time` out CNT_WIDTH: last measured rising-to-falling time in `clock_in` cycles.
- `stalled` out 1: level; high while in STALL.
- `edge_count` out 16: number of ticks since reset; wraps.

## Operation

- **Synchronizer:** `s1 <- div_clock`, `s2 <- s1`, `s3 <- s2`. It runs regardless of `enable`.
- **Edge detection:** rise = `s2 & ~s3`; fall = `~s2 & s3`.
- **Counter `cnt`:** increments every cycle while state is ARM_WAIT… see states below (counts in MEASURE and STALL). It saturates at all-ones and never wraps.

**States**

- **IDLE:** entered when `enable` = 0. No ticks. `cnt` holds at 0. `stalled` = 0. Outputs `period` and `high_time` hold.
- **ARM:** entered from IDLE when `enable` = 1.
  - On rise: `tick`, `cnt <- 1`, go to MEASURE.
  - No `period_valid`, because the first edge has no reference.
- **MEASURE:**
  - On rise: `tick`, `period <- cnt`, `period_valid` = 1, `cnt <- 1`.
  - On fall: `high_time <- cnt`.
  - Otherwise `cnt <- cnt + 1`.
  - When `cnt` reaches `TIMEOUT_CYCLES` with no rise in that cycle: go to STALL.
- **STALL:** `stalled` = 1 and `cnt` keeps counting (saturating).
  - On rise: `tick`, `cnt <- 1`, go to MEASURE, `stalled` falls.
  - No `period_valid` on this recovery edge.

**Rules and boundary conditions**

- `enable` falling in any state: go to IDLE on the next edge. A rise in that same cycle is ignored.
- Simultaneous rise and timeout: the rise wins; no stall is declared.
- `edge_count` increments on every `tick` and wraps from 0xFFFF to 0x0000.
- Fall in ARM or STALL: ignored. `high_time` is not updated.

## Timing

- **Reset values:**
  - `tick`, `period_valid` and `stalled`: 0.
  - `period`, `high_time` and `edge_count`: 0.
  - State: IDLE; `s1`, `s2`, `s3` and `cnt`: 0.
- **Reset mid-operation:** all of the above apply immediately, asynchronously. The first tick after release requires a fresh rise.
- **Tick latency:** `tick` is registered. It is high for exactly one cycle, starting 3 `clock_in` edges after the first edge that samples `div_clock` high.
- **Output update timing:**
  - `period`, `period_valid` and `edge_count` update in the same cycle as `tick`.
  - `high_time` updates with a 3-cycle latency from the falling edge.
- **Period accuracy:** `period` equals N exactly for a `div_clock` that is synchronous and periodic with period N ≥ 2 `clock_in` cycles.
- **Stall timing:** `stalled` rises `TIMEOUT_CYCLES` cycles after the last tick, counting the tick cycle as `cnt` = 1.

## Configuration

- **`CLKMON_STALL_EN` defined:** STALL state and timeout logic are present as described.
- **`CLKMON_STALL_EN` undefined:** STALL state and timeout comparator are removed.
  - `stalled` is tied to 0.
  - MEASURE persists indefinitely, and `cnt` saturates at 2^CNT_WIDTH−1.
  - A rise after saturation reports `period` = all-ones with `period_valid`.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan

- **Reset:** assert `reset` mid-count → all outputs 0 immediately; after release, `enable` = 1 and the first rise give `tick` with no `period_valid`; `edge_count` = 1.
- **Steady divide-by-10:** drive `div_clock` 5 high / 5 low, `enable` = 1 → `tick` every 10 cycles; `period` = 10 with `period_valid` from the 2nd tick on; `high_time` = 5.
- **Divide-by-2:** drive `div_clock` 1 high / 1 low → `period` = 2, `high_time` = 1, tick every 2 cycles.
- **Stall and recovery** (`CLKMON_STALL_EN`, `TIMEOUT_CYCLES` = 20): hold `div_clock` low after a tick → `stalled` = 1 exactly 19 cycles after the tick cycle. Resume edges → `stalled` = 0 on the next `tick`, with no `period_valid`; the following period is correct.
- **Enable gating:** drop `enable` for 30 cycles during divide-by-10 → no ticks, outputs hold. After re-enable, the first rise gives no `period_valid`; the second gives `period` = 10.
- **Wrap:** preload 65535 ticks (or force) → next `tick` gives `edge_count` = 0.
